// File: rtl/tt_um_onehot_decoder.sv
// Registered 3-to-8 decoder. It produces a one-hot or thermometer pattern from a loaded
// index, and it can hold that index or sweep it up/down at a programmable rate.
module tt_um_onehot_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  logic [7:0] sync1, sync2;
  logic       strobe_d;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;

  logic [2:0] code_s;
  logic       strobe_s, run_s, dir_s, mode_s, clear_s, load_pulse;
  logic [3:0] period;
  logic       valid;
  logic [7:0] onehot;

  // ena and the upper uio_in bits have no function in this tile.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  // The period is quasi-static: it only changes outside SWEEP, so it needs no synchroniser.
  assign period     = uio_in[3:0];
  assign code_s     = sync2[2:0];
  assign strobe_s   = sync2[3];
  assign run_s      = sync2[4];
  assign dir_s      = sync2[5];
  assign mode_s     = sync2[6];
  assign clear_s    = sync2[7];
  assign load_pulse = strobe_s & ~strobe_d;

  // NOTE: use non-blocking (<=) in clocked blocks. Every flop then samples the
  // pre-edge value, and the chain behaves as a real shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      strobe_d <= 1'b0;
    end else begin
      sync1    <= ui_in;
      sync2    <= sync1;
      strobe_d <= strobe_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: every signal driven here gets a default value first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    if (clear_s) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else if (load_pulse) begin
      idx_n   = code_s;
      cnt_n   = '0;
      state_n = run_s ? SWEEP : HOLD;
    end else begin
      unique case (state)
        HOLD: begin
          if (run_s) begin
            state_n = SWEEP;
            cnt_n   = '0;
          end
        end
        SWEEP: begin
          if (!run_s) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else if (cnt >= period) begin
            // >= rather than == lets a mid-count decrease of P take effect at once.
            idx_n = dir_s ? idx + 3'd1 : idx - 3'd1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Thermometer = (onehot << 1) - 1 in 8 bits. For idx=7 the shift wraps to 0, which gives 8'hFF.
  assign valid   = (state != IDLE);
  assign onehot  = 8'd1 << idx;
  assign uo_out  = !valid ? 8'h00 : (mode_s ? ({onehot[6:0], 1'b0} - 8'd1) : onehot);
  assign uio_out = {valid, idx, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_onehot_decoder.sv
// Directed self-checking bench for tt_um_onehot_decoder. Outputs are observed as
// {uo_out, uio_out}, and inputs are driven and sampled on the falling clock edge.
module tb_tt_um_onehot_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uio_in = 8'h00;

  logic [2:0] code = 3'd0;
  logic       load = 1'b0, run = 1'b0, dir = 1'b0, mode = 1'b0, clr = 1'b0;
  logic [7:0] ui_in;
  logic [15:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  assign ui_in = {clr, mode, dir, run, load, code};
  assign obs   = {uo_out, uio_out};

  tt_um_onehot_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Two strobe-low cycles carrying the new code/run/dir, then a strobe rise. The task returns
  // on the falling edge just after the third rising edge, when the load has taken effect.
  task automatic do_load(input logic [2:0] c, input logic r, input logic d);
    code = c; run = r; dir = d; load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_tests++; if (obs !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h expected 0000", obs); end
    n_tests++; if (uio_oe !== 8'hF0) begin n_fail++; $display("FAIL uio_oe: got %h expected f0", uio_oe); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (obs !== 16'h0000) begin n_fail++; $display("FAIL idle_after_reset: got %h expected 0000", obs); end
  endtask

  task automatic test_load_hold;
    code = 3'd5; mode = 1'b0; run = 1'b0;
    @(negedge clk);
    load = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (obs !== 16'h0000) begin n_fail++; $display("FAIL load_latency_e2: got %h expected 0000", obs); end
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (obs !== 16'h20D0) begin n_fail++; $display("FAIL load5_e3: got %h expected 20d0", obs); end
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++; if (obs !== 16'h20D0) begin n_fail++; $display("FAIL hold5 cyc%0d: got %h expected 20d0", i, obs); end
    end
  endtask

  task automatic test_mode;
    mode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (obs !== 16'h3FD0) begin n_fail++; $display("FAIL therm5: got %h expected 3fd0", obs); end
    do_load(3'd0, 1'b0, 1'b0);
    n_tests++; if (obs !== 16'h0180) begin n_fail++; $display("FAIL therm0: got %h expected 0180", obs); end
    do_load(3'd7, 1'b0, 1'b0);
    n_tests++; if (obs !== 16'hFFF0) begin n_fail++; $display("FAIL therm7: got %h expected fff0", obs); end
  endtask

  task automatic test_sweep_up;
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h40E0; exp_seq[1] = 16'h80F0; exp_seq[2] = 16'h0180; exp_seq[3] = 16'h0290;
    mode = 1'b0;
    uio_in = 8'h02;
    do_load(3'd6, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (obs !== exp_seq[k/3]) begin n_fail++; $display("FAIL sweep_up k%0d: got %h expected %h", k, obs, exp_seq[k/3]); end
      @(negedge clk);
    end
  endtask

  task automatic test_sweep_down;
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h0290; exp_seq[1] = 16'h0180; exp_seq[2] = 16'h80F0; exp_seq[3] = 16'h40E0;
    run = 1'b0;
    repeat (4) @(negedge clk);
    uio_in = 8'h00;
    do_load(3'd1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (obs !== exp_seq[k]) begin n_fail++; $display("FAIL sweep_down k%0d: got %h expected %h", k, obs, exp_seq[k]); end
      if (k < 3) @(negedge clk);
    end
    // Run falls while idx=6. Two more steps (5, 4) happen before the state sees the drop.
    run = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (obs !== 16'h10C0) begin n_fail++; $display("FAIL freeze: got %h expected 10c0", obs); end
    repeat (5) @(negedge clk);
    n_tests++; if (obs !== 16'h10C0) begin n_fail++; $display("FAIL frozen_hold: got %h expected 10c0", obs); end
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (obs !== 16'h10C0) begin n_fail++; $display("FAIL resume_entry: got %h expected 10c0", obs); end
    @(negedge clk);
    n_tests++; if (obs !== 16'h08B0) begin n_fail++; $display("FAIL resume_step1: got %h expected 08b0", obs); end
    @(negedge clk);
    n_tests++; if (obs !== 16'h04A0) begin n_fail++; $display("FAIL resume_step2: got %h expected 04a0", obs); end
  endtask

  task automatic test_clear_over_load;
    code = 3'd3;
    clr = 1'b1; load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (obs !== 16'h0000) begin n_fail++; $display("FAIL clear_wins: got %h expected 0000", obs); end
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++; if (obs !== 16'h0000) begin n_fail++; $display("FAIL idle_no_sweep cyc%0d: got %h expected 0000", i, obs); end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_sweep;
    uio_in = 8'h03;
    do_load(3'd2, 1'b1, 1'b1);
    n_tests++; if (obs !== 16'h04A0) begin n_fail++; $display("FAIL load2_sweep: got %h expected 04a0", obs); end
    @(negedge clk);
    load = 1'b1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (obs !== 16'h0000) begin n_fail++; $display("FAIL async_reset: got %h expected 0000", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      n_tests++; if (obs !== 16'h0000) begin n_fail++; $display("FAIL no_early_load e%0d: got %h expected 0000", e, obs); end
    end
    @(negedge clk);
    n_tests++; if (obs !== 16'h04A0) begin n_fail++; $display("FAIL load_after_release: got %h expected 04a0", obs); end
    repeat (3) @(negedge clk);
    n_tests++; if (obs !== 16'h04A0) begin n_fail++; $display("FAIL p3_before_step: got %h expected 04a0", obs); end
    @(negedge clk);
    n_tests++; if (obs !== 16'h08B0) begin n_fail++; $display("FAIL single_load_step: got %h expected 08b0", obs); end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_mode();
    test_sweep_up();
    test_sweep_down();
    test_clear_over_load();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
